// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and width helper for the UART transmitter
package uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_e;
  function automatic int CeilLog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_tick_counter.sv
// uart_tick_counter: wrapping baud counter with a terminal flag at MAXIMUM_VALUE-1
module uart_tick_counter #(
  parameter int MAXIMUM_VALUE = 434,
  parameter int NBITS = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  output logic [NBITS-1:0] count,
  output logic             flag
);
  assign flag = count == NBITS'(MAXIMUM_VALUE - 1);
  always_ff @(negedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= flag ? '0 : count + NBITS'(1);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: falling-edge UART transmitter, start + LSB-first payload + stop bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS = 8,
  parameter int NBITS = CeilLog2(CLKS_PER_BIT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);
  localparam int IW = CeilLog2(DATA_BITS);
  state_e               state_q;
  logic [DATA_BITS-1:0] sh_q;
  logic [IW-1:0]        idx_q;
  logic                 tx_q, busy_q, done_q;
  logic [NBITS-1:0]     baud_cnt;
  logic                 tick, last_bit, leave;
  assign last_bit = idx_q == IW'(DATA_BITS - 1);
  // a DATA tick between bits is not a state change, so the counter just wraps there
  assign leave = state_q == IDLE ? tx_start : tick & (state_q != DATA | last_bit);
  uart_tick_counter #(.MAXIMUM_VALUE(CLKS_PER_BIT), .NBITS(NBITS)) u_baud (
    .clk   (clk),
    .reset (reset),
    .enable(state_q != IDLE),
    .clear (leave),
    .count (baud_cnt),
    .flag  (tick)
  );
  always_ff @(negedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (tx_start) begin
          state_q <= START;
          sh_q    <= tx_data;
          idx_q   <= '0;
          tx_q    <= 1'b0;
          busy_q  <= 1'b1;
        end
        START: if (tick) begin
          state_q <= DATA;
          tx_q    <= sh_q[0];
          sh_q    <= sh_q >> 1;
        end
        DATA: if (tick) begin
          if (last_bit) begin
            state_q <= STOP;
            idx_q   <= '0;
            tx_q    <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
            tx_q  <= sh_q[0];
            sh_q  <= sh_q >> 1;
          end
        end
        STOP: if (tick) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      endcase
    end
  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
  baud_in_range: assert property (@(negedge clk) disable iff (!reset) int'(baud_cnt) < CLKS_PER_BIT);
endmodule
